// File: rtl/gvp_program_loader.sv
// gvp_program_loader: halts the GVP, programs reset options, vectors and presets over
// its config bus, releases reset and then waits for the program to finish.
module gvp_program_loader #(
    parameter int NUM_VECTORS_N2     = 4,
    parameter int CONTROL_ADDR       = 1,
    parameter int RESET_OPTIONS_ADDR = 2,
    parameter int VECTOR_PROG_ADDR   = 3,
    parameter int VECTOR_PRESET_ADDR = 4,
    parameter int IDLE_ADDR          = 0,
    parameter int WRITE_HOLD         = 8,
    parameter int RESET_SETTLE       = 16
) (
    input  logic                      a_clk,
    input  logic                      a_resetn,
    input  logic [31:0]               s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic                      cmd_start,
    input  logic                      cmd_abort,
    input  logic [NUM_VECTORS_N2:0]   cmd_nvec,
    input  logic [15:0]               cmd_options,
    input  logic [31:0]               preset_u,
    input  logic [31:0]               preset_a,
    input  logic [31:0]               preset_b,
    input  logic                      gvp_finished,
    output logic [31:0]               config_addr,
    output logic [511:0]              config_data,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [3:0]                state,
    output logic [NUM_VECTORS_N2:0]   vec_count
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, HALT = 4'd1, SETTLE = 4'd2, OPTS = 4'd3, COLLECT = 4'd4, VWRITE = 4'd5,
        VGAP = 4'd6, PRESET = 4'd7, RUN = 4'd8, WATCH = 4'd9, ABORT = 4'd10
    } state_t;

    localparam logic [NUM_VECTORS_N2:0] MAX_VEC = {1'b1, {NUM_VECTORS_N2{1'b0}}};

    state_t                    r_state, w_next;
    logic [15:0]               r_cnt;
    logic [3:0]                r_word;
    logic [511:0]              r_buf, w_buf, w_data;
    logic [NUM_VECTORS_N2:0]   r_nvec;
    logic [15:0]               r_opts;
    logic [31:0]               r_u, r_a, r_b, w_addr;
    logic                      w_acc, w_hold, w_start_ok, w_frame_err;

    assign state = r_state;

    always_comb begin
        w_acc       = s_axis_tvalid & s_axis_tready;
        w_hold      = r_cnt == 16'(WRITE_HOLD - 1);
        w_start_ok  = cmd_nvec != '0 && cmd_nvec <= MAX_VEC;
        // word 0 carries the vector slot address; tlast must mark exactly word 15
        w_frame_err = w_acc && ((r_word == 4'd0 && s_axis_tdata[31:NUM_VECTORS_N2] != '0) ||
                                (s_axis_tlast != (r_word == 4'd15)));
        w_buf = r_buf;
        if (w_acc)
            w_buf[{r_word, 5'd0} +: 32] = s_axis_tdata;
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (cmd_start && w_start_ok) ? HALT : IDLE;
            HALT:    w_next = w_hold ? SETTLE : HALT;
            SETTLE:  w_next = (r_cnt == 16'(RESET_SETTLE - 1)) ? OPTS : SETTLE;
            OPTS:    w_next = w_hold ? COLLECT : OPTS;
            COLLECT: w_next = w_frame_err ? ABORT : (w_acc && r_word == 4'd15) ? VWRITE : COLLECT;
            VWRITE:  w_next = w_hold ? VGAP : VWRITE;
            VGAP:    w_next = !w_hold ? VGAP : (vec_count < r_nvec) ? COLLECT : PRESET;
            PRESET:  w_next = w_hold ? RUN : PRESET;
            RUN:     w_next = w_hold ? WATCH : RUN;
            WATCH:   w_next = gvp_finished ? IDLE : WATCH;
            ABORT:   w_next = w_hold ? IDLE : ABORT;
            default: w_next = IDLE;
        endcase
        if (cmd_abort && r_state != IDLE && r_state != ABORT)
            w_next = ABORT;
        // bus outputs are computed for the upcoming state so the registered bus lines up with it
        w_addr = 32'(IDLE_ADDR);
        w_data = '0;
        case (w_next)
            HALT, ABORT: begin w_addr = 32'(CONTROL_ADDR); w_data = 512'd1; end
            OPTS:        begin w_addr = 32'(RESET_OPTIONS_ADDR); w_data[15:0] = r_opts; end
            VWRITE:      begin w_addr = 32'(VECTOR_PROG_ADDR); w_data = w_buf; end
            PRESET: begin
                w_addr          = 32'(VECTOR_PRESET_ADDR);
                w_data[127:96]  = r_u;
                w_data[159:128] = r_a;
                w_data[191:160] = r_b;
            end
            RUN:         w_addr = 32'(CONTROL_ADDR);
            default:     w_addr = 32'(IDLE_ADDR);
        endcase
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_word        <= '0;
            r_buf         <= '0;
            r_nvec        <= '0;
            r_opts        <= '0;
            r_u           <= '0;
            r_a           <= '0;
            r_b           <= '0;
            s_axis_tready <= 1'b0;
            config_addr   <= 32'(IDLE_ADDR);
            config_data   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            vec_count     <= '0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
            r_word        <= (r_state == COLLECT && w_next == COLLECT) ? r_word + {3'b0, w_acc} : 4'd0;
            r_buf         <= w_buf;
            s_axis_tready <= w_next == COLLECT;
            config_addr   <= w_addr;
            config_data   <= w_data;
            busy          <= w_next != IDLE;
            done          <= r_state == WATCH && w_next == IDLE;
            if (r_state == IDLE && cmd_start) begin
                if (w_start_ok) begin
                    r_nvec    <= cmd_nvec;
                    r_opts    <= cmd_options;
                    r_u       <= preset_u;
                    r_a       <= preset_a;
                    r_b       <= preset_b;
                    error     <= 1'b0;
                    vec_count <= '0;
                end else begin
                    error <= 1'b1;
                end
            end
            if (w_frame_err)
                error <= 1'b1;
            if (r_state == VWRITE && w_next == VGAP)
                vec_count <= vec_count + {{NUM_VECTORS_N2{1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_gvp_program_loader.sv
// tb_gvp_program_loader: directed bench for the GVP program loader; records the config
// address runs (address, length, first data) and checks them against hand-derived tables.
module tb_gvp_program_loader;
    logic         a_clk = 1'b0, a_resetn = 1'b0;
    logic [31:0]  s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic         cmd_start = 1'b0, cmd_abort = 1'b0, gvp_finished = 1'b0;
    logic [4:0]   cmd_nvec = '0;
    logic [15:0]  cmd_options = '0;
    logic [31:0]  preset_u = '0, preset_a = '0, preset_b = '0;
    logic [31:0]  config_addr;
    logic [511:0] config_data;
    logic         busy, done, error;
    logic [3:0]   state;
    logic [4:0]   vec_count;

    int errors = 0, checks = 0;
    logic rec = 1'b0;
    int run_addr[$];
    int run_len[$];
    logic [511:0] run_data[$];

    gvp_program_loader dut (
        .a_clk(a_clk), .a_resetn(a_resetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort), .cmd_nvec(cmd_nvec),
        .cmd_options(cmd_options), .preset_u(preset_u), .preset_a(preset_a),
        .preset_b(preset_b), .gvp_finished(gvp_finished),
        .config_addr(config_addr), .config_data(config_data),
        .busy(busy), .done(done), .error(error), .state(state), .vec_count(vec_count)
    );

    always #5 a_clk = ~a_clk;

    always @(negedge a_clk) begin
        if (rec) begin
            if (run_addr.size() == 0 || int'(config_addr) != run_addr[run_addr.size()-1]) begin
                run_addr.push_back(int'(config_addr));
                run_len.push_back(1);
                run_data.push_back(config_data);
            end else begin
                run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
            end
        end
    end

    task automatic step();
        @(posedge a_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] blk(input int b);
        logic [511:0] r;
        for (int k = 0; k < 16; k++)
            r[32*k +: 32] = (k == 0) ? 32'(b) : (k == 1) ? 32'd10 : 32'hA000_0000 + 32'(b * 256 + k);
        return r;
    endfunction

    task automatic send_block(input int b, input int nw, input int lastpos, input logic [31:0] w0);
        logic [511:0] bb;
        int n;
        bb = blk(b);
        for (int k = 0; k < nw; k++) begin
            s_axis_tdata  = (k == 0) ? w0 : bb[32*k +: 32];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (k == lastpos);
            n = 0;
            while (!s_axis_tready && n < 300) begin
                step();
                n++;
            end
            chk("tready_wait", 512'(s_axis_tready), 512'd1);
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input string tag);
        int n = 0;
        while (state !== s && n < 500) begin
            step();
            n++;
        end
        chk(tag, 512'(state), 512'(s));
    endtask

    task automatic start(input logic [4:0] nv);
        cmd_nvec  = nv;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_addr[11] = '{1, 0, 2, 0, 3, 0, 3, 0, 4, 1, 0};
        int exp_len[10]  = '{8, 16, 8, 16, 8, 24, 8, 8, 8, 8};
        logic [511:0] exp_p;
        repeat (3) step();
        chk("rst_addr", 512'(config_addr), 512'd0);
        chk("rst_data", config_data, 512'd0);
        chk("rst_ready_busy_done_err", 512'({s_axis_tready, busy, done, error}), 512'd0);
        chk("rst_state_vc", 512'({state, vec_count}), 512'd0);
        a_resetn = 1'b1;
        step();

        start(5'd0);
        chk("nvec0_error", 512'(error), 512'd1);
        chk("nvec0_stay_idle", 512'({state, busy}), 512'd0);

        cmd_options = 16'hBEEF;
        preset_u = 32'h1111_1111; preset_a = 32'h2222_2222; preset_b = 32'h3333_3333;
        start(5'd2);
        rec = 1'b1;
        chk("start_clears_error", 512'(error), 512'd0);
        chk("start_halt", 512'({state, busy}), 512'({4'd1, 1'b1}));
        send_block(0, 16, 15, 32'd0);
        send_block(1, 16, 15, 32'd1);
        wait_state(4'd9, "reach_watch");
        repeat (49) step();
        chk("watch_no_done", 512'({done, state}), 512'({1'b0, 4'd9}));
        gvp_finished = 1'b1;
        step();
        gvp_finished = 1'b0;
        chk("done_pulse", 512'(done), 512'd1);
        chk("done_idle", 512'({state, busy}), 512'd0);
        chk("vec_count_2", 512'(vec_count), 512'd2);
        step();
        rec = 1'b0;
        chk("done_one_cycle", 512'(done), 512'd0);
        chk("run_count", 512'(run_addr.size()), 512'd11);
        for (int i = 0; i < 11 && i < run_addr.size(); i++)
            chk($sformatf("run%0d_addr", i), 512'(run_addr[i]), 512'(exp_addr[i]));
        for (int i = 0; i < 10 && i < run_len.size(); i++)
            chk($sformatf("run%0d_len", i), 512'(run_len[i]), 512'(exp_len[i]));
        exp_p = '0;
        exp_p[127:96] = 32'h1111_1111; exp_p[159:128] = 32'h2222_2222; exp_p[191:160] = 32'h3333_3333;
        if (run_data.size() >= 10) begin
            chk("halt_data", run_data[0], 512'd1);
            chk("opts_data", run_data[2], 512'h BEEF);
            chk("vec0_data", run_data[4], blk(0));
            chk("vec1_data", run_data[6], blk(1));
            chk("preset_data", run_data[8], exp_p);
            chk("run_data", run_data[9], 512'd0);
        end

        start(5'd1);
        send_block(0, 8, 7, 32'd0);
        chk("early_tlast_error", 512'(error), 512'd1);
        chk("early_tlast_abort", 512'({state, config_addr}), 512'({4'd10, 32'd1}));
        chk("abort_data", config_data, 512'd1);
        repeat (7) step();
        chk("abort_hold", 512'({state, config_addr}), 512'({4'd10, 32'd1}));
        step();
        chk("abort_to_idle", 512'({state, config_addr, error}), 512'({4'd0, 32'd0, 1'b1}));

        start(5'd1);
        chk("restart_clears_error", 512'(error), 512'd0);
        wait_state(4'd4, "reach_collect_a");
        send_block(0, 1, 15, 32'd16);
        chk("bad_addr_error", 512'({error, state}), 512'({1'b1, 4'd10}));
        repeat (8) step();
        chk("bad_addr_idle", 512'(state), 512'd0);

        start(5'd2);
        chk("restart2_clears_error", 512'(error), 512'd0);
        repeat (3) step();
        cmd_nvec = 5'd0;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        chk("start_ignored_busy", 512'({state, error}), 512'({4'd1, 1'b0}));
        send_block(0, 16, 15, 32'd0);
        send_block(1, 16, 15, 32'd1);
        chk("second_vwrite", 512'({state, vec_count}), 512'({4'd5, 5'd1}));
        repeat (3) step();
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        chk("cmd_abort_state", 512'({state, config_addr}), 512'({4'd10, 32'd1}));
        chk("cmd_abort_data", config_data, 512'd1);
        chk("cmd_abort_vec_count", 512'({vec_count, error}), 512'({5'd1, 1'b0}));
        repeat (8) step();
        chk("cmd_abort_idle", 512'({state, busy}), 512'd0);

        start(5'd1);
        wait_state(4'd4, "reach_collect_b");
        repeat (100) step();
        chk("stall_hold", 512'({state, s_axis_tready, error}), 512'({4'd4, 1'b1, 1'b0}));
        send_block(0, 3, 15, 32'd0);
        a_resetn = 1'b0;
        #1;
        chk("async_rst_state", 512'({state, vec_count}), 512'd0);
        chk("async_rst_flags", 512'({s_axis_tready, busy, done, error}), 512'd0);
        chk("async_rst_bus", 512'(config_addr) | config_data, 512'd0);
        step();
        a_resetn = 1'b1;
        step();
        chk("post_rst_idle", 512'({state, busy}), 512'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
